// File: rtl/td4_pkg.sv
// Shared constants for the TD4 run/load controller: state encoding and program memory geometry.
package td4_pkg;
  localparam int TD4_PROG_DEPTH = 16;
  localparam int TD4_ADDR_W     = 4;
  localparam int TD4_WORD_W     = 8;

  localparam logic [1:0] ST_HALT = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_STEP = 2'd3;
endpackage

// File: rtl/td4_prescaler.sv
// Run-mode prescaler: counts 0..PRESC_DIV-1 while clr is low; tick is combinational, one cycle
// ahead of the terminal count, so a registered enable taken from it lines up with count==PRESC_DIV-1.
module td4_prescaler #(
  parameter int PRESC_W   = 24,
  parameter int PRESC_DIV = 12000000
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  output logic tick
);
  localparam logic [PRESC_W-1:0] LAST = PRESC_W'(PRESC_DIV - 1);
  localparam logic [PRESC_W-1:0] PRE  = PRESC_W'(PRESC_DIV - 2);

  logic [PRESC_W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (!reset || clr) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + PRESC_W'(1);
    end
  end

  assign tick = !clr && (cnt == PRE);
endmodule

// File: rtl/td4_run_ctrl.sv
// TD4 run/load controller: HALT/LOAD/RUN/STEP sequencing, core enable/reset and program RAM writes.
// Optional breakpoint halt in RUN is built only when TD4_BREAKPOINT_EN is defined.
module td4_run_ctrl
  import td4_pkg::*;
#(
  parameter int PRESC_W   = 24,
  parameter int PRESC_DIV = 12000000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  mode_load,
  input  logic                  btn_run,
  input  logic                  btn_step,
  input  logic                  btn_wr,
  input  logic [TD4_WORD_W-1:0] sw_data,
  input  logic [TD4_ADDR_W-1:0] core_ip,
  input  logic [TD4_ADDR_W-1:0] bp_addr,
  output logic                  core_en,
  output logic                  core_rst_n,
  output logic                  prog_we,
  output logic [TD4_ADDR_W-1:0] prog_addr,
  output logic [TD4_WORD_W-1:0] prog_wdata,
  output logic [1:0]            state_o
);
  logic [1:0]            st;
  logic [1:0]            st_nxt;
  logic                  en_nxt;
  logic                  tick;
  logic                  wr_ok;
  logic [TD4_ADDR_W-1:0] wp;
  logic                  bp_hit;

  td4_prescaler #(.PRESC_W(PRESC_W), .PRESC_DIV(PRESC_DIV)) u_presc (
    .clock (clock),
    .reset (reset),
    .clr   (st != ST_RUN),
    .tick  (tick)
  );

`ifdef TD4_BREAKPOINT_EN
  logic first_tick;

  // The first tick of every run is exempt so a resume executes the breakpointed instruction.
  always_ff @(posedge clock) begin
    if (!reset || st != ST_RUN) begin
      first_tick <= 1'b1;
    end else if (tick) begin
      first_tick <= 1'b0;
    end
  end

  assign bp_hit = !first_tick && (core_ip == bp_addr);
`else
  logic unused_bp;
  assign unused_bp = ^{bp_addr, core_ip};
  assign bp_hit    = 1'b0;
`endif

  always_comb begin
    st_nxt = st;
    en_nxt = 1'b0;
    case (st)
      ST_HALT: begin
        if (mode_load) begin
          st_nxt = ST_LOAD;
        end else if (btn_run) begin
          st_nxt = ST_RUN;
        end else if (btn_step) begin
          st_nxt = ST_STEP;
          en_nxt = 1'b1;
        end
      end
      ST_LOAD: begin
        if (!mode_load) st_nxt = ST_HALT;
      end
      ST_RUN: begin
        if (mode_load) begin
          st_nxt = ST_LOAD;
        end else if (btn_run) begin
          st_nxt = ST_HALT;
        end else if (tick) begin
          if (bp_hit) st_nxt = ST_HALT;
          else        en_nxt = 1'b1;
        end
      end
      default: st_nxt = ST_HALT;
    endcase
  end

  // A write raised in the cycle LOAD is released is dropped.
  assign wr_ok = (st == ST_LOAD) && mode_load && btn_wr;

  always_ff @(posedge clock) begin
    if (!reset) begin
      st         <= ST_HALT;
      core_en    <= 1'b0;
      core_rst_n <= 1'b0;
      prog_we    <= 1'b0;
      prog_addr  <= '0;
      prog_wdata <= '0;
      wp         <= '0;
    end else begin
      st         <= st_nxt;
      core_en    <= en_nxt;
      core_rst_n <= (st_nxt != ST_LOAD);
      prog_we    <= wr_ok;
      if (wr_ok) begin
        prog_addr  <= wp;
        prog_wdata <= sw_data;
        wp         <= wp + TD4_ADDR_W'(1);
      end else if (st != ST_LOAD) begin
        wp <= '0;
      end
    end
  end

  assign state_o = st;
endmodule

// File: tb/tb_td4_run_ctrl.sv
// Randomized scoreboard bench for td4_run_ctrl with PRESC_DIV=4; expected outputs are queued per cycle.
module tb_td4_run_ctrl;
  localparam int DIV = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       mode_load = 1'b0;
  logic       btn_run = 1'b0;
  logic       btn_step = 1'b0;
  logic       btn_wr = 1'b0;
  logic [7:0] sw_data = 8'h00;
  logic [3:0] core_ip = 4'h0;
  logic [3:0] bp_addr = 4'h3;
  logic       core_en, core_rst_n, prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_wdata;
  logic [1:0] state_o;

  td4_run_ctrl #(.PRESC_W(8), .PRESC_DIV(DIV)) dut (
    .clock      (clock),
    .reset      (reset),
    .mode_load  (mode_load),
    .btn_run    (btn_run),
    .btn_step   (btn_step),
    .btn_wr     (btn_wr),
    .sw_data    (sw_data),
    .core_ip    (core_ip),
    .bp_addr    (bp_addr),
    .core_en    (core_en),
    .core_rst_n (core_rst_n),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_wdata (prog_wdata),
    .state_o    (state_o)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  typedef struct {
    int         c;
    logic [4:0] v;
  } exp_t;

  exp_t        exp_q[$];
  logic [11:0] wr_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  // Reference model: mode 0=HALT 1=LOAD 2=RUN 3=STEP, ticks derived from cycles since RUN began.
  int m_mode = 0;
  int m_wp = 0;
  int m_start = 0;
  bit m_first = 1'b1;
  int m_ip = 0;
  bit m_en = 1'b0;
  bit m_rst_n = 1'b0;
  bit ml_lvl = 1'b0;

  task automatic step_cycle(input bit rst, input bit br, input bit bs, input bit bw, input logic [7:0] sd);
    int nm;
    bit nen;
    bit nwe;
    bit nrst;
    bit hit;
    nm  = m_mode;
    nen = 1'b0;
    nwe = 1'b0;
    hit = 1'b0;
    reset     = rst;
    mode_load = ml_lvl;
    btn_run   = br;
    btn_step  = bs;
    btn_wr    = bw;
    sw_data   = sd;
    core_ip   = 4'(m_ip);
    if (!rst) begin
      nm   = 0;
      m_wp = 0;
    end else begin
      case (m_mode)
        0: begin
          if (ml_lvl) nm = 1;
          else if (br) begin
            nm = 2;
            m_start = cyc + 1;
            m_first = 1'b1;
          end else if (bs) begin
            nm  = 3;
            nen = 1'b1;
          end
        end
        1: begin
          if (!ml_lvl) begin
            nm   = 0;
            m_wp = 0;
          end else if (bw) begin
            nwe = 1'b1;
            wr_q.push_back({4'(m_wp), sd});
            m_wp = (m_wp + 1) % 16;
          end
        end
        2: begin
          if (ml_lvl) nm = 1;
          else if (br) nm = 0;
          else if (((cyc + 2 - m_start) % DIV) == 0) begin
`ifdef TD4_BREAKPOINT_EN
            hit = !m_first && (m_ip == int'(bp_addr));
`endif
            if (hit) nm = 0;
            else     nen = 1'b1;
            m_first = 1'b0;
          end
        end
        default: nm = 0;
      endcase
    end
    nrst = rst && (nm != 1);
    exp_q.push_back('{cyc + 1, {2'(nm), nen, nrst, nwe}});
    m_ip    = m_rst_n ? (m_ip + int'(m_en)) % 16 : 0;
    m_en    = nen;
    m_rst_n = nrst;
    m_mode  = nm;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step_cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  exp_t        mon_e;
  logic [11:0] mon_w;
  logic [4:0]  mon_a;

  always @(negedge clock) begin
    while (exp_q.size() > 0 && exp_q[0].c <= cyc) begin
      mon_e = exp_q.pop_front();
      mon_a = {state_o, core_en, core_rst_n, prog_we};
      n_cmp++;
      if (mon_a !== mon_e.v) begin
        n_bad++;
        $display("FAIL outputs cyc=%0d got st/en/rstn/we=%b required %b", cyc, mon_a, mon_e.v);
      end
    end
    if (prog_we === 1'b1) begin
      n_cmp++;
      if (wr_q.size() == 0) begin
        n_bad++;
        $display("FAIL write cyc=%0d unexpected write addr=%0d data=%h", cyc, prog_addr, prog_wdata);
      end else begin
        mon_w = wr_q.pop_front();
        if ({prog_addr, prog_wdata} !== mon_w) begin
          n_bad++;
          $display("FAIL write cyc=%0d got addr/data=%h required %h", cyc, {prog_addr, prog_wdata}, mon_w);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clock);
    #1;
    repeat (3) step_cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    idle(4);

    // Program load: AC, 6C, then 15 more so the 17th wraps to address 0.
    ml_lvl = 1'b1;
    idle(2);
    step_cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'hAC);
    idle(1);
    step_cycle(1'b1, 1'b1, 1'b1, 1'b1, 8'h6C);
    for (int i = 0; i < 15; i++) begin
      step_cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'($urandom));
      idle(i % 2);
    end
    ml_lvl = 1'b0;
    step_cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'h55);
    idle(3);

    for (int i = 0; i < 3; i++) begin
      step_cycle(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
      idle(4);
    end

    step_cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    idle(9);
    step_cycle(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    idle(4);

    ml_lvl = 1'b1;
    step_cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    idle(3);
    ml_lvl = 1'b0;
    idle(2);

    // Breakpoint walk from ip 0 with bp_addr=3, then resume past it.
    bp_addr = 4'h3;
    step_cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    idle(20);
    step_cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    idle(6);
    step_cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    idle(2);

    step_cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    idle(5);
    step_cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    idle(2);
    ml_lvl = 1'b1;
    idle(2);
    step_cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'h11);
    step_cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h22);
    idle(3);
    ml_lvl = 1'b0;
    idle(2);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) ml_lvl = !ml_lvl;
      if ($urandom_range(0, 99) == 0) bp_addr = 4'($urandom);
      step_cycle($urandom_range(0, 199) != 0, $urandom_range(0, 24) == 0,
                 $urandom_range(0, 14) == 0, $urandom_range(0, 3) == 0, 8'($urandom));
    end
    ml_lvl = 1'b0;
    idle(3);
    @(negedge clock);
    #1;
    n_cmp++;
    if (exp_q.size() != 0 || wr_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain leftover outputs=%0d writes=%0d required 0/0", exp_q.size(), wr_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
